// File: rtl/pulse_stretch.sv
// Pulse-to-level converter: each accepted EN pulse gives HOLD clocks high, then GAP clocks low.
// Optional macro RETRIGGER_EN: EN during the high interval extends it instead of queueing.
module pulse_stretch #(
  parameter int unsigned CW   = 24,
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 2,
  parameter int unsigned PW   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  output logic          LVL,
  output logic          BUSY,
  output logic [PW-1:0] PEND,
  output logic          DROP
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } state_t;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
  localparam logic [PW-1:0] PMAX    = '1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pend, pend_nx;
  logic          drop, drop_nx;
  logic          enqueue;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      drop  <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    drop_nx  = 1'b0;
    enqueue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (EN) begin
          state_nx = ST_HIGH;
          cnt_nx   = HOLD_LD;
        end
      end
      ST_HIGH: begin
`ifdef RETRIGGER_EN
        if (EN) begin
          cnt_nx = HOLD_LD;
        end else if (cnt == '0) begin
          state_nx = ST_GAP;
          cnt_nx   = GAP_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
`else
        enqueue = EN;
        if (cnt == '0) begin
          state_nx = ST_GAP;
          cnt_nx   = GAP_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_nx  = cnt - CW'(1);
          enqueue = EN;
        end else if ((pend != '0) || EN) begin
          // A simultaneous EN replaces the dequeued request, so PEND only drops when EN is low.
          state_nx = ST_HIGH;
          cnt_nx   = HOLD_LD;
          if ((pend != '0) && !EN) pend_nx = pend - PW'(1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (enqueue) begin
      if (pend == PMAX) drop_nx = 1'b1;
      else              pend_nx = pend + PW'(1);
    end
  end

  always_comb begin
    LVL  = (state == ST_HIGH);
    BUSY = (state != ST_IDLE);
  end

  assign PEND = pend;
  assign DROP = drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed self-checking bench for pulse_stretch with HOLD=4, GAP=2, PW=2.
module tb_pulse_stretch;
  localparam int unsigned PW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          LVL;
  logic          BUSY;
  logic [PW-1:0] PEND;
  logic          DROP;

  int tests  = 0;
  int failed = 0;

  pulse_stretch #(.CW(24), .HOLD(4), .GAP(2), .PW(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .LVL (LVL),
    .BUSY(BUSY),
    .PEND(PEND),
    .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int lvl, input int busy,
                           input int pend, input int drop);
    check({tag, ".lvl"},  32'(LVL),  32'(lvl));
    check({tag, ".busy"}, 32'(BUSY), 32'(busy));
    check({tag, ".pend"}, 32'(PEND), 32'(pend));
    check({tag, ".drop"}, 32'(DROP), 32'(drop));
  endtask

  // Drive EN for the next rising edge, then sample 1 ns after it.
  task automatic step(input logic en);
    EN = en;
    @(posedge CLK);
    #1;
  endtask

  // Single pulse followed by a request exactly on the last gap cycle.
  int en_sim   [13] = '{1,0,0,0,0,0,1,0,0,0,0,0,0};
  int lvl_sim  [13] = '{1,1,1,1,0,0,1,1,1,1,0,0,0};
  int busy_sim [13] = '{1,1,1,1,1,1,1,1,1,1,1,1,0};

`ifdef RETRIGGER_EN
  int en_rt   [9] = '{1,0,1,0,0,0,0,0,0};
  int lvl_rt  [9] = '{1,1,1,1,1,1,0,0,0};
  int busy_rt [9] = '{1,1,1,1,1,1,1,1,0};
`else
  int en_b2b   [19] = '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int lvl_b2b  [19] = '{1,1,1,1,0,0,1,1,1,1,0,0,1,1,1,1,0,0,0};
  int busy_b2b [19] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
  int pend_b2b [19] = '{0,1,2,2,2,2,1,1,1,1,1,1,0,0,0,0,0,0,0};

  int en_sat   [8] = '{1,1,1,1,1,1,1,0};
  int lvl_sat  [8] = '{1,1,1,1,0,0,1,1};
  int pend_sat [8] = '{0,1,2,3,3,3,3,3};
  int drop_sat [8] = '{0,0,0,0,1,1,0,0};
`endif

  initial begin
    RST = 1'b1;
    EN  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all("reset", 0, 0, 0, 0);
    RST = 1'b0;
    step(1'b0);
    check_all("idle", 0, 0, 0, 0);

    // Single pulse: 4 high, 2 low, idle after 6 edges.
    step(1'b1);
    check_all("single[0]", 1, 1, 0, 0);
    for (int i = 1; i < 7; i++) begin
      step(1'b0);
      check_all($sformatf("single[%0d]", i), (i < 4) ? 1 : 0, (i < 6) ? 1 : 0, 0, 0);
    end

    for (int i = 0; i < 13; i++) begin
      step(1'(en_sim[i]));
      check_all($sformatf("simul[%0d]", i), lvl_sim[i], busy_sim[i], 0, 0);
    end

`ifdef RETRIGGER_EN
    for (int i = 0; i < 9; i++) begin
      step(1'(en_rt[i]));
      check_all($sformatf("retrig[%0d]", i), lvl_rt[i], busy_rt[i], 0, 0);
    end
`else
    for (int i = 0; i < 19; i++) begin
      step(1'(en_b2b[i]));
      check_all($sformatf("b2b[%0d]", i), lvl_b2b[i], busy_b2b[i], pend_b2b[i], 0);
    end

    for (int i = 0; i < 8; i++) begin
      step(1'(en_sat[i]));
      check_all($sformatf("sat[%0d]", i), lvl_sat[i], 1, pend_sat[i], drop_sat[i]);
    end

    // Asynchronous reset from a saturated queue.
    #1;
    RST = 1'b1;
    #1;
    check_all("sat_rst", 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Build PEND=2 mid-interval, then reset 2 ns after an edge.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check_all("pre_rst", 1, 1, 2, 0);
`endif

    #1;
    RST = 1'b1;
    EN  = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    check_all("rst_hold_en", 0, 0, 0, 0);
    RST = 1'b0;

    step(1'b1);
    check_all("fresh[0]", 1, 1, 0, 0);
    for (int i = 1; i < 7; i++) begin
      step(1'b0);
      check_all($sformatf("fresh[%0d]", i), (i < 4) ? 1 : 0, (i < 6) ? 1 : 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
